alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 37 +++
 rtl/alu_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice:
//   WIDTH_DEF  - default operand/result width
//   FLAG_*     - bit positions inside the 5-bit flag vector
//   state_e    - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    // Flag vector layout: {overflow, parity, carry, sign, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_SIGN  = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_PAR   = 3;
    localparam int FLAG_OVF   = 4;
    localparam int NUM_FLAGS  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational adder with status flags.
// Ports:
//   a_i, b_i  - WIDTH-bit operands
//   sum_o     - a + b modulo 2^WIDTH
//   flags_o   - {overflow, parity, carry, sign, zero}
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [WIDTH-1:0]     sum_o,
    output logic [NUM_FLAGS-1:0] flags_o
);

    // One extra bit to catch the carry-out of the add.
    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = full_sum[WIDTH-1:0];

    always_comb begin
        flags_o             = '0;
        flags_o[FLAG_ZERO]  = (full_sum[WIDTH-1:0] == '0);
        flags_o[FLAG_SIGN]  = full_sum[WIDTH-1];
        flags_o[FLAG_CARRY] = full_sum[WIDTH];
        flags_o[FLAG_PAR]   = ^full_sum[WIDTH-1:0];
        // Signed overflow: operands agree in sign, result disagrees.
        flags_o[FLAG_OVF]   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                              (full_sum[WIDTH-1] != a_i[WIDTH-1]);
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one adder (alu_core) between NUM_REQ requesters using a round-robin
// grant. One transaction is in flight at a time: IDLE (grant + capture),
// EXEC (register sum/flags), RESP (hold result until rsp_ready).
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   req_valid        - per-requester request
//   req_a, req_b     - packed operands, requester i in [i*WIDTH +: WIDTH]
//   req_ready        - one-hot acceptance (combinational, IDLE only)
//   req_lock         - (ALU_ARBITER_LOCK_EN only) keep priority on grant
//   rsp_valid        - result available (RESP state)
//   rsp_ready        - consumer accepts the result
//   rsp_id           - index of the requester owning the result
//   rsp_sum          - a + b modulo 2^WIDTH
//   rsp_flags        - {overflow, parity, carry, sign, zero}
//   busy             - high whenever not IDLE
//
// Build option: define ALU_ARBITER_LOCK_EN to add the req_lock input.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
`ifdef ALU_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic [NUM_FLAGS-1:0]       rsp_flags,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    // Per-requester view of the packed operand buses.
    logic [NUM_REQ-1:0][WIDTH-1:0] a_arr;
    logic [NUM_REQ-1:0][WIDTH-1:0] b_arr;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // State and datapath registers.
    state_e                 state_q, state_d;
    logic [IDW-1:0]         ptr_q,   ptr_d;
    logic [WIDTH-1:0]       a_q,     a_d;
    logic [WIDTH-1:0]       b_q,     b_d;
    logic [IDW-1:0]         id_q,    id_d;
    logic [WIDTH-1:0]       sum_q,   sum_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;

    // Adder outputs for the captured operands.
    logic [WIDTH-1:0]       core_sum;
    logic [NUM_FLAGS-1:0]   core_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i     (a_q),
        .b_i     (b_q),
        .sum_o   (core_sum),
        .flags_o (core_flags)
    );

    // -------------------------------------------------------------------------
    // Round-robin search: walk from ptr_q upward with wrap, first valid wins.
    // The candidate index carries one extra bit so ptr + k never overflows
    // before the wrap subtraction.
    // -------------------------------------------------------------------------
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   cand;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    // Pointer value after a plain round-robin grant.
    logic [IDW-1:0] ptr_inc;

    assign ptr_inc = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // -------------------------------------------------------------------------
    // FSM next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        sum_d     = sum_q;
        flags_d   = flags_q;
        req_ready = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_idx] = 1'b1;
                    a_d                = a_arr[gnt_idx];
                    b_d                = b_arr[gnt_idx];
                    id_d               = gnt_idx;
                    state_d            = ST_EXEC;
`ifdef ALU_ARBITER_LOCK_EN
                    // A locked winner parks the pointer on itself so it is
                    // searched first again next round.
                    ptr_d = req_lock[gnt_idx] ? gnt_idx : ptr_inc;
`else
                    ptr_d = ptr_inc;
`endif
                end
            end
            ST_EXEC: begin
                sum_d   = core_sum;
                flags_d = core_flags;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The grant is combinational off IDLE, so mask it while reset is held.
        if (rst) begin
            req_ready = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_flags = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Scoreboard bench: stimulus pushes expected grants and responses into queues,
// a monitor compares them as the DUT grants and presents results.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_valid;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [W-1:0]       rsp_sum;
    logic [4:0]         rsp_flags;
    logic               busy;
`ifdef ALU_ARBITER_LOCK_EN
    logic [N-1:0]       req_lock;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ALU_ARBITER_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_flags (rsp_flags),
        .busy      (busy)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   sum;
        logic [4:0]     flags;
    } rsp_t;

    rsp_t exp_q[$];
    int   gnt_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   gnt_cnt   = 0;
    int   cyc       = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic expect_rsp(input int id, input logic [W-1:0] s, input logic [4:0] f);
        rsp_t e;
        e.id    = IDW'(id);
        e.sum   = s;
        e.flags = f;
        exp_q.push_back(e);
    endtask

    // Returns just after the acceptance edge of grant number n.
    task automatic wait_gnt(input int n);
        int t = 0;
        while (gnt_cnt < n && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (gnt_cnt < n) fail("grant_timeout");
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        int target;
        set_op(i, a, b);
        target       = gnt_cnt + 1;
        req_valid[i] = 1'b1;
        wait_gnt(target);
        req_valid[i] = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Monitor: samples on the falling edge, pops and compares.
    // -------------------------------------------------------------------------
    task automatic monitor();
        rsp_t e, cur, prev;
        logic prev_v      = 1'b0;
        logic prev_hs     = 1'b0;
        logic outstanding = 1'b0;
        int   acc_cyc     = 0;
        int   idx;
        prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {rsp_id, rsp_sum, rsp_flags};
            if (rst) begin
                chk_eq("reset_outputs",
                       32'({rsp_valid, busy, req_ready, rsp_id, rsp_sum, rsp_flags}), 32'd0);
                outstanding = 1'b0;
                prev_v      = 1'b0;
            end else begin
                if (|req_ready) begin
                    idx = 0;
                    for (int k = 0; k < N; k++) if (req_ready[k]) idx = k;
                    chk_eq("grant_onehot", 32'($onehot(req_ready)), 32'd1);
                    chk_eq("grant_without_valid", 32'(req_ready & ~req_valid), 32'd0);
                    chk_eq("grant_while_pending", 32'(outstanding), 32'd0);
                    chk_eq("busy_at_grant", 32'(busy), 32'd0);
                    if (gnt_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL grant_unexpected: got req %0d expected none", idx);
                    end else begin
                        chk_eq("grant_order", 32'(idx), 32'(gnt_q.pop_front()));
                    end
                    gnt_cnt++;
                    acc_cyc     = cyc;
                    outstanding = 1'b1;
                end
                if (rsp_valid) begin
                    chk_eq("ready_in_resp", 32'(req_ready), 32'd0);
                    chk_eq("busy_in_resp", 32'(busy), 32'd1);
                    if (!prev_v) chk_eq("latency", 32'(cyc - acc_cyc), 32'd2);
                    else if (!prev_hs) chk_eq("rsp_stable", 32'(cur), 32'(prev));
                    if (rsp_ready) begin
                        if (exp_q.size() == 0) begin
                            total_cnt++;
                            $display("FAIL rsp_unexpected: got id %0d expected none", rsp_id);
                        end else begin
                            e = exp_q.pop_front();
                            chk_eq("rsp_id", 32'(rsp_id), 32'(e.id));
                            chk_eq("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                            chk_eq("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                        end
                        outstanding = 1'b0;
                    end
                    prev    = cur;
                    prev_hs = rsp_ready;
                end
                prev_v = rsp_valid;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    task automatic stimulus();
        int base;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
`ifdef ALU_ARBITER_LOCK_EN
        req_lock  = '0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single requests, flags {ovf,par,carry,sign,zero}.
        gnt_q.push_back(0); expect_rsp(0, 16'h0000, 5'b00101);
        issue(0, 16'hFFFF, 16'h0001);
        gnt_q.push_back(1); expect_rsp(1, 16'hFFFE, 5'b01110);
        issue(1, 16'hFFFF, 16'hFFFF);
        gnt_q.push_back(2); expect_rsp(2, 16'h7FFF, 5'b11100);
        issue(2, 16'hFFFF, 16'h8000);
        drain();

        // All four valid from reset: 0,1,2,3,0.
        do_reset();
        set_op(0, 16'h0001, 16'h0002);
        set_op(1, 16'h7FFF, 16'h0001);
        set_op(2, 16'h1234, 16'h4321);
        set_op(3, 16'h8000, 16'h8000);
        gnt_q.push_back(0); expect_rsp(0, 16'h0003, 5'b00000);
        gnt_q.push_back(1); expect_rsp(1, 16'h8000, 5'b11010);
        gnt_q.push_back(2); expect_rsp(2, 16'h5555, 5'b00000);
        gnt_q.push_back(3); expect_rsp(3, 16'h0000, 5'b10101);
        gnt_q.push_back(0); expect_rsp(0, 16'h0003, 5'b00000);
        base      = gnt_cnt;
        req_valid = 4'hF;
        wait_gnt(base + 5);
        req_valid = '0;
        drain();

        // Backpressure: result held 5 cycles, req2 waits for the handshake.
        rsp_ready = 1'b0;
        set_op(1, 16'h0100, 16'h0011);
        set_op(2, 16'h0000, 16'h0000);
        gnt_q.push_back(1); expect_rsp(1, 16'h0111, 5'b01000);
        gnt_q.push_back(2); expect_rsp(2, 16'h0000, 5'b00001);
        base      = gnt_cnt;
        req_valid = 4'b0110;
        wait_gnt(base + 1);
        req_valid[1] = 1'b0;
        begin
            int t = 0;
            while (!rsp_valid && t < 20) begin
                @(posedge clk);
                t++;
            end
            if (!rsp_valid) fail("rsp_valid_timeout");
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_gnt(base + 2);
        req_valid[2] = 1'b0;
        drain();

        // Reset while in EXEC: no response, pointer back to 0.
        set_op(1, 16'h1111, 16'h2222);
        gnt_q.push_back(1);
        base         = gnt_cnt;
        req_valid[1] = 1'b1;
        wait_gnt(base + 1);
        req_valid[1] = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        set_op(0, 16'h0005, 16'h0003);
        set_op(3, 16'h0003, 16'h0004);
        gnt_q.push_back(0); expect_rsp(0, 16'h0008, 5'b01000);
        gnt_q.push_back(3); expect_rsp(3, 16'h0007, 5'b01000);
        base      = gnt_cnt;
        req_valid = 4'b1001;
        wait_gnt(base + 1);
        req_valid[0] = 1'b0;
        wait_gnt(base + 2);
        req_valid[3] = 1'b0;
        drain();

`ifdef ALU_ARBITER_LOCK_EN
        // Lock on req2: granted three times, then req3 once lock drops.
        do_reset();
        set_op(2, 16'h0001, 16'h0001);
        set_op(3, 16'h0003, 16'h0004);
        for (int k = 0; k < 3; k++) begin
            gnt_q.push_back(2); expect_rsp(2, 16'h0002, 5'b01000);
        end
        gnt_q.push_back(3); expect_rsp(3, 16'h0007, 5'b01000);
        base        = gnt_cnt;
        req_lock[2] = 1'b1;
        req_valid   = 4'b1100;
        wait_gnt(base + 2);
        req_lock[2] = 1'b0;
        wait_gnt(base + 4);
        req_valid   = '0;
        drain();
`endif
        chk_eq("grants_consumed", 32'(gnt_q.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                repeat (20000) @(posedge clk);
                fail("watchdog");
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
